// File: rtl/enc_pwm_mixer.sv
// enc_pwm_mixer: quadrature encoder to PWM mixer.
//   Each channel synchronises and debounces its enc_a/enc_b pair and decodes
//   x1 quadrature into a PWM_WIDTH-bit level. A shared free-running counter
//   drives one registered PWM output per channel. The duty is a shadow copy
//   of the level, refreshed only at the end of each period.
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   enc_a, enc_b [CHANNELS]            asynchronous quadrature phases
//   pwm_out      [CHANNELS]            registered PWM outputs
//   level_out    [CHANNELS*PWM_WIDTH]  live level, channel i at [i*PWM_WIDTH +: PWM_WIDTH]
//   period_start                       high in the cycle pwm_cnt == 0
// Optional build macro: ENC_PWM_MIXER_SATURATE_EN (level saturates instead of wrapping).

// Two-flop synchroniser followed by a stable-count debouncer.
module enc_pwm_deb #(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_LEN - 1);

  logic [1:0] sync;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      // Counting only while the synchronised level differs from the output;
      // a return to the output level restarts the count.
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// One channel: debouncers, x1 decoder, level, shadow duty, PWM compare.
module enc_pwm_chan #(
  parameter int PWM_WIDTH    = 8,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  input  logic                 duty_load,
  output logic [PWM_WIDTH-1:0] level,
  output logic                 pwm_out
);
  localparam logic [PWM_WIDTH-1:0] MAX = '1;

  logic                 filt_a, filt_b, filt_a_d;
  logic                 inc, dec;
  logic [PWM_WIDTH-1:0] duty;
  logic                 rise;

  enc_pwm_deb #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_deb_a (
    .clk(clk), .reset_n(reset_n), .din(enc_a), .dout(filt_a));
  enc_pwm_deb #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_deb_b (
    .clk(clk), .reset_n(reset_n), .din(enc_b), .dout(filt_b));

  assign rise = filt_a & ~filt_a_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_a_d <= 1'b0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      level    <= '0;
      duty     <= '0;
      pwm_out  <= 1'b0;
    end else begin
      filt_a_d <= filt_a;
      // Registered step pulses put the level update at DEBOUNCE_LEN+3.
      inc      <= rise & ~filt_b;
      dec      <= rise &  filt_b;
`ifdef ENC_PWM_MIXER_SATURATE_EN
      if (inc && level != MAX)
        level <= level + 1'b1;
      else if (dec && level != '0)
        level <= level - 1'b1;
`else
      if (inc)
        level <= level + 1'b1;
      else if (dec)
        level <= level - 1'b1;
`endif
      if (duty_load)
        duty <= level;
      pwm_out <= (pwm_cnt < duty);
    end
  end
endmodule

module enc_pwm_mixer #(
  parameter int CHANNELS     = 3,
  parameter int PWM_WIDTH    = 8,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           enc_a,
  input  logic [CHANNELS-1:0]           enc_b,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic [CHANNELS*PWM_WIDTH-1:0] level_out,
  output logic                          period_start
);
  localparam logic [PWM_WIDTH-1:0] MAX = '1;

  logic                 started;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] cnt_nxt;
  logic                 duty_load;

  // The counter holds at 0 through the release edge so the first cycle out
  // of reset is a period start.
  assign cnt_nxt   = started ? pwm_cnt + 1'b1 : '0;
  assign duty_load = (pwm_cnt == MAX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      started      <= 1'b0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      started      <= 1'b1;
      pwm_cnt      <= cnt_nxt;
      period_start <= (cnt_nxt == '0);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    enc_pwm_chan #(
      .PWM_WIDTH   (PWM_WIDTH),
      .DEBOUNCE_LEN(DEBOUNCE_LEN)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .enc_a    (enc_a[i]),
      .enc_b    (enc_b[i]),
      .pwm_cnt  (pwm_cnt),
      .duty_load(duty_load),
      .level    (level_out[i*PWM_WIDTH +: PWM_WIDTH]),
      .pwm_out  (pwm_out[i])
    );
  end
endmodule

// File: doc/enc_pwm_mixer.md
ENC_PWM_MIXER -- requirements
Module: enc_pwm_mixer

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of encoder/PWM channels, legal 1..8.
REQ-002 SHALL have parameter PWM_WIDTH, default 8: per-channel level and PWM counter width, legal 4..12.
REQ-003 SHALL have parameter DEBOUNCE_LEN, default 4: consecutive stable cycles required to accept an input level, legal 1..255.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous and active-low.
REQ-006 enc_a  input  CHANNELS  quadrature phase A per channel, asynchronous.
REQ-007 enc_b  input  CHANNELS  quadrature phase B per channel, asynchronous.
REQ-008 pwm_out  output  CHANNELS  registered PWM output per channel.
REQ-009 level_out  output  CHANNELS*PWM_WIDTH  current level per channel, channel i at bits [i*PWM_WIDTH +: PWM_WIDTH].
REQ-010 period_start  output  1  one-cycle pulse at each PWM period start.

Function
REQ-011 Each enc_a/enc_b bit SHALL pass through a two-flop synchroniser before any other use.
REQ-012 Each synchronised bit SHALL drive an independent debouncer: its filtered output takes the synchronised level only after that level has been stable for DEBOUNCE_LEN consecutive cycles; any change restarts the count.
REQ-013 Decoding SHALL be x1: on a filtered-A rising edge, level increments by 1 if filtered B is 0, decrements by 1 if filtered B is 1; filtered-A falling edges and B edges alone SHALL not change level.
REQ-014 Level update latency SHALL be exactly DEBOUNCE_LEN+3 cycles from the first clk edge sampling the new enc_a level, given stable inputs.
REQ-015 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each update their own level in the same cycle.
REQ-016 A single shared free-running counter pwm_cnt (PWM_WIDTH bits) SHALL count 0..2^PWM_WIDTH-1 and wrap to 0; period_start SHALL assert in the cycle pwm_cnt equals 0.
REQ-017 Each channel SHALL hold a shadow duty register loaded from level only in the cycle pwm_cnt equals 2^PWM_WIDTH-1, so a level change never alters the current period.
REQ-018 pwm_out[i] SHALL be registered (pwm_cnt < duty[i]): duty 0 gives constant low; duty 2^PWM_WIDTH-1 gives high for 2^PWM_WIDTH-1 of every 2^PWM_WIDTH cycles.
REQ-019 level_out SHALL reflect level directly (not the shadow duty), with no extra delay beyond the level register.

Reset
REQ-020 While reset_n is sampled low: synchronisers, debouncer outputs and counts, level, duty and pwm_cnt SHALL be 0; pwm_out and period_start SHALL be 0.
REQ-021 The first cycle after reset_n is sampled high SHALL have pwm_cnt 0 and period_start 1.
REQ-022 Reset asserted mid-period or mid-debounce SHALL abandon all in-progress counts with no level change from pending edges.
REQ-023 Debouncer outputs reset to 0, so an enc_a held high through reset SHALL produce one rising edge after release once debounced.

Configuration
REQ-024 With macro ENC_PWM_MIXER_SATURATE_EN defined, level SHALL saturate: increment at 2^PWM_WIDTH-1 and decrement at 0 leave level unchanged.
REQ-025 Without ENC_PWM_MIXER_SATURATE_EN, level SHALL wrap modulo 2^PWM_WIDTH (0 minus 1 gives 2^PWM_WIDTH-1; max plus 1 gives 0).

Verification
REQ-026 Defaults; 5 clean A-rising edges with B=0 on channel 1 -> level_out ch1 = 5, ch0/ch2 = 0, each update DEBOUNCE_LEN+3 = 7 cycles after edge.
REQ-027 Defaults; 2-cycle glitch on enc_a[0] -> no level change on any channel.
REQ-028 Defaults; level 64 loaded mid-period -> pwm_out unchanged until next period_start, then high exactly 64 of 256 cycles; level 0 -> constant low; 255 -> high 255 of 256.
REQ-029 Defaults; one decrement from level 0 -> 255 without macro, 0 with ENC_PWM_MIXER_SATURATE_EN; increment from 255 -> 0 without, 255 with.
REQ-030 CHANNELS=8, PWM_WIDTH=4; simultaneous increments on all channels -> all levels 1 in the same cycle; pwm period 16 cycles.
REQ-031 reset_n low for 1 cycle mid-period with level 10 -> all outputs 0, level 0, period_start 1 on first cycle after release.
